opcode_issue_queue: RTL and testbench

Buffered issue stage directly upstream of the opcode decoder. Accepts 4-bit opcodes with their three 2-bit operands over a valid/ready handshake, holds them in a small in-order FIFO, and presents one entry at a time to the decoder. Optionally, each opcode is pre-classified at push time with the decoder's priority rules (1??? / 01?? / 001? / default). The decoder can then mux on a registered select instead of re-evaluating the opcode.

---
 rtl/opq_pkg.sv | 34 +++
 rtl/opq_predecode.sv | 35 +++
 rtl/opcode_issue_queue.sv | 160 ++++++++++++++++
 tb/tb_opcode_issue_queue.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/opq_pkg.sv
// Shared definitions for the opcode issue queue.
//
// Contents:
//   OPC_W, OPND_W : opcode width and operand width
//   sel_t         : pre-decode class handed to the decoder
//                   (SEL_NONE=0, SEL_A=1, SEL_B=2, SEL_C=3)
//   payload_t     : opcode plus its three operands
//   entry_t       : payload plus its pre-decode class

package opq_pkg;

  localparam int OPC_W  = 4;
  localparam int OPND_W = 2;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_A    = 2'd1,
    SEL_B    = 2'd2,
    SEL_C    = 2'd3
  } sel_t;

  typedef struct packed {
    logic [OPC_W-1:0]  opcode;
    logic [OPND_W-1:0] a;
    logic [OPND_W-1:0] b;
    logic [OPND_W-1:0] c;
  } payload_t;

  typedef struct packed {
    payload_t payload;
    sel_t     sel;
  } entry_t;

endpackage

// File: rtl/opq_predecode.sv
// Combinational opcode classifier using the decoder's priority rules.
//
// Ports:
//   opcode_i : opcode being pushed into the queue
//   sel_o    : class, first match wins:
//              1??? -> SEL_A, 01?? -> SEL_B, 001? -> SEL_C, otherwise SEL_NONE
//
// Unknown opcode bits (X/Z) are treated as 0 when classifying. The queue
// stores the opcode itself unchanged.

module opq_predecode
  import opq_pkg::*;
(
  input  logic [OPC_W-1:0] opcode_i,
  output sel_t             sel_o
);

  // Copying into a 2-state variable turns X/Z into 0. Classification therefore
  // never produces an unknown select.
  bit [OPC_W-1:0] opcKnown;
  assign opcKnown = opcode_i;

  // Priority chain. Each later test relies on the higher bits having been 0.
  always_comb begin
    sel_o = SEL_NONE;
    if (opcKnown[3]) begin
      sel_o = SEL_A;
    end else if (opcKnown[2]) begin
      sel_o = SEL_B;
    end else if (opcKnown[1]) begin
      sel_o = SEL_C;
    end
  end

endmodule

// File: rtl/opcode_issue_queue.sv
// In-order issue queue that sits in front of the opcode decoder.
//
// Parameter:
//   DEPTH : number of entries (power of two, >= 2)
//
// Ports:
//   clk, reset              : rising-edge clock; asynchronous active-high reset
//   flush                   : synchronous discard of every queued entry (wins over push/pop)
//   in_valid / in_ready     : producer handshake; in_ready = (count != DEPTH)
//   in_opcode, in_a/b/c     : pushed entry
//   out_valid / out_ready   : decoder handshake; out_valid = (count != 0)
//   out_opcode, out_a/b/c   : head entry. Driven to 0 while the queue is empty.
//   out_sel                 : pre-decode class of the head entry
//   count                   : current occupancy
//
// Build option:
//   OPQ_PREDECODE_EN : classify each opcode at push time and store the class
//                      with the entry. Without it, out_sel is tied to 0 and no
//                      classification logic is built.

module opcode_issue_queue
  import opq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [OPC_W-1:0]         in_opcode,
  input  logic [OPND_W-1:0]        in_a,
  input  logic [OPND_W-1:0]        in_b,
  input  logic [OPND_W-1:0]        in_c,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OPC_W-1:0]         out_opcode,
  output logic [OPND_W-1:0]        out_a,
  output logic [OPND_W-1:0]        out_b,
  output logic [OPND_W-1:0]        out_c,
  output logic [1:0]               out_sel,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0] count_q, count_d;

  payload_t mem_q [DEPTH];
  payload_t pushPayload;
  payload_t headPayload;

  logic push;
  logic pop;

  // The handshake flags come only from the occupancy count. A full queue does
  // not accept a push even in a cycle where it pops, so nothing passes through.
  assign in_ready  = (count_q != CNT_FULL);
  assign out_valid = (count_q != '0);
  assign count     = count_q;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  assign pushPayload = '{opcode: in_opcode, a: in_a, b: in_b, c: in_c};
  assign headPayload = mem_q[rdPtr_q];

  // Next-state for pointers and occupancy. Flush clears everything and drops
  // any push in the same cycle. Otherwise each pointer advances on its own
  // handshake, and count moves only when exactly one of push and pop happens.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (flush) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (push) begin
        wrPtr_d = wrPtr_q + PTR_ONE;
      end
      if (pop) begin
        rdPtr_d = rdPtr_q + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state. Reset is asynchronous, so the handshake flags clear the
  // moment reset rises.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Entry storage has no reset. The count guarantees that a stale slot is
  // never presented at the output.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_q[wrPtr_q] <= pushPayload;
    end
  end

  // The head is read straight from storage, so a pop shows the next entry on
  // the same edge. The payload is forced to 0 while the queue is empty.
  always_comb begin
    out_opcode = '0;
    out_a      = '0;
    out_b      = '0;
    out_c      = '0;
    if (out_valid) begin
      out_opcode = headPayload.opcode;
      out_a      = headPayload.a;
      out_b      = headPayload.b;
      out_c      = headPayload.c;
    end
  end

`ifdef OPQ_PREDECODE_EN
  sel_t pushSel;
  sel_t selMem_q [DEPTH];

  opq_predecode u_predecode (
    .opcode_i (in_opcode),
    .sel_o    (pushSel)
  );

  // The class is stored next to the payload, so the decoder gets a registered
  // select for the head and does not have to re-evaluate the opcode.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      selMem_q[wrPtr_q] <= pushSel;
    end
  end

  assign out_sel = out_valid ? selMem_q[rdPtr_q] : SEL_NONE;
`else
  assign out_sel = 2'b00;
`endif

endmodule

// File: tb/tb_opcode_issue_queue.sv
// Directed, table-driven bench for opcode_issue_queue (DEPTH=4).
// Each table row holds the inputs for one clock cycle and the outputs
// expected just after that cycle's rising edge. Hand-written sequences cover
// the reset state and an asynchronous reset that arrives in mid-cycle.

module tb_opcode_issue_queue;

  import opq_pkg::*;

`ifdef OPQ_PREDECODE_EN
  localparam bit PREDEC = 1'b1;
`else
  localparam bit PREDEC = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_opcode;
  logic [1:0] in_a, in_b, in_c;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_opcode;
  logic [1:0] out_a, out_b, out_c;
  logic [1:0] out_sel;
  logic [2:0] count;

  int errors = 0;
  int checks = 0;

  opcode_issue_queue #(.DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_opcode  (in_opcode),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_c       (in_c),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_opcode (out_opcode),
    .out_a      (out_a),
    .out_b      (out_b),
    .out_c      (out_c),
    .out_sel    (out_sel),
    .count      (count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       inValid;
    logic [3:0] inOpcode;
    logic [1:0] inA, inB, inC;
    logic       outReady;
    logic       doFlush;
    logic       expValid;
    logic [3:0] expOpcode;
    logic [1:0] expA, expB, expC, expSel;
    logic [2:0] expCount;
    logic       expReady;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkVec(
    input logic iv, input logic [3:0] op, input logic [1:0] a, input logic [1:0] b,
    input logic [1:0] c, input logic ordy, input logic fl,
    input logic ev, input logic [3:0] eop, input logic [1:0] ea, input logic [1:0] eb,
    input logic [1:0] ec, input logic [1:0] esel, input logic [2:0] ecnt, input logic erdy);
    vec_t v;
    v.inValid = iv;  v.inOpcode = op; v.inA = a; v.inB = b; v.inC = c;
    v.outReady = ordy; v.doFlush = fl;
    v.expValid = ev; v.expOpcode = eop; v.expA = ea; v.expB = eb; v.expC = ec;
    v.expSel = esel; v.expCount = ecnt; v.expReady = erdy;
    return v;
  endfunction

  task automatic checkField(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Compares every output. The expected class only applies when the
  // pre-decode build option is enabled; otherwise out_sel must read 0.
  task automatic checkOutput(input string tag, input logic ev, input logic [3:0] eop,
                             input logic [1:0] ea, input logic [1:0] eb, input logic [1:0] ec,
                             input logic [1:0] esel, input logic [2:0] ecnt, input logic erdy);
    logic [1:0] selExp;
    selExp = PREDEC ? esel : 2'd0;
    checkField({tag, " out_valid"},  int'(out_valid),  int'(ev));
    checkField({tag, " out_opcode"}, int'(out_opcode), int'(eop));
    checkField({tag, " out_a"},      int'(out_a),      int'(ea));
    checkField({tag, " out_b"},      int'(out_b),      int'(eb));
    checkField({tag, " out_c"},      int'(out_c),      int'(ec));
    checkField({tag, " out_sel"},    int'(out_sel),    int'(selExp));
    checkField({tag, " count"},      int'(count),      int'(ecnt));
    checkField({tag, " in_ready"},   int'(in_ready),   int'(erdy));
  endtask

  // Drives one row of inputs away from the clock edge, lets one rising edge
  // pass, and leaves time just after that edge so the caller can sample.
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    in_valid  = v.inValid;
    in_opcode = v.inOpcode;
    in_a      = v.inA;
    in_b      = v.inB;
    in_c      = v.inC;
    out_ready = v.outReady;
    flush     = v.doFlush;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_opcode = 4'd0; in_a = 2'd0; in_b = 2'd0; in_c = 2'd0;

    // Row layout:
    //   inputs:   iv, opcode, a, b, c, out_ready, flush
    //   expected: valid, opcode, a, b, c, sel, count, in_ready
    // Fill to full with out_ready low, then attempt a fifth push.
    vecs.push_back(mkVec(1'b1,4'b1010,2'd1,2'd2,2'd3,1'b0,1'b0, 1'b1,4'b1010,2'd1,2'd2,2'd3,2'd1,3'd1,1'b1));
    vecs.push_back(mkVec(1'b1,4'b0101,2'd0,2'd1,2'd2,1'b0,1'b0, 1'b1,4'b1010,2'd1,2'd2,2'd3,2'd1,3'd2,1'b1));
    vecs.push_back(mkVec(1'b1,4'b0010,2'd3,2'd3,2'd3,1'b0,1'b0, 1'b1,4'b1010,2'd1,2'd2,2'd3,2'd1,3'd3,1'b1));
    vecs.push_back(mkVec(1'b1,4'b0000,2'd2,2'd0,2'd1,1'b0,1'b0, 1'b1,4'b1010,2'd1,2'd2,2'd3,2'd1,3'd4,1'b0));
    vecs.push_back(mkVec(1'b1,4'b1111,2'd3,2'd3,2'd3,1'b0,1'b0, 1'b1,4'b1010,2'd1,2'd2,2'd3,2'd1,3'd4,1'b0));
    // Drain: the classes come out as 2, 3, 0, and 1111 never appears.
    vecs.push_back(mkVec(1'b0,4'b0000,2'd0,2'd0,2'd0,1'b1,1'b0, 1'b1,4'b0101,2'd0,2'd1,2'd2,2'd2,3'd3,1'b1));
    vecs.push_back(mkVec(1'b0,4'b0000,2'd0,2'd0,2'd0,1'b1,1'b0, 1'b1,4'b0010,2'd3,2'd3,2'd3,2'd3,3'd2,1'b1));
    vecs.push_back(mkVec(1'b0,4'b0000,2'd0,2'd0,2'd0,1'b1,1'b0, 1'b1,4'b0000,2'd2,2'd0,2'd1,2'd0,3'd1,1'b1));
    vecs.push_back(mkVec(1'b0,4'b0000,2'd0,2'd0,2'd0,1'b1,1'b0, 1'b0,4'b0000,2'd0,2'd0,2'd0,2'd0,3'd0,1'b1));
    // Streaming at count=2: the head advances every cycle with no gaps.
    vecs.push_back(mkVec(1'b1,4'b0100,2'd1,2'd1,2'd1,1'b0,1'b0, 1'b1,4'b0100,2'd1,2'd1,2'd1,2'd2,3'd1,1'b1));
    vecs.push_back(mkVec(1'b1,4'b0011,2'd2,2'd2,2'd2,1'b0,1'b0, 1'b1,4'b0100,2'd1,2'd1,2'd1,2'd2,3'd2,1'b1));
    vecs.push_back(mkVec(1'b1,4'b1000,2'd3,2'd0,2'd0,1'b1,1'b0, 1'b1,4'b0011,2'd2,2'd2,2'd2,2'd3,3'd2,1'b1));
    vecs.push_back(mkVec(1'b1,4'b0001,2'd0,2'd0,2'd3,1'b1,1'b0, 1'b1,4'b1000,2'd3,2'd0,2'd0,2'd1,3'd2,1'b1));
    vecs.push_back(mkVec(1'b1,4'b1100,2'd1,2'd2,2'd0,1'b1,1'b0, 1'b1,4'b0001,2'd0,2'd0,2'd3,2'd0,3'd2,1'b1));
    // Reach count=3, then flush together with a push. The flushed push must never show up.
    vecs.push_back(mkVec(1'b1,4'b0110,2'd0,2'd3,2'd1,1'b0,1'b0, 1'b1,4'b0001,2'd0,2'd0,2'd3,2'd0,3'd3,1'b1));
    vecs.push_back(mkVec(1'b1,4'b1001,2'd1,2'd1,2'd1,1'b0,1'b1, 1'b0,4'b0000,2'd0,2'd0,2'd0,2'd0,3'd0,1'b1));
    vecs.push_back(mkVec(1'b0,4'b0000,2'd0,2'd0,2'd0,1'b1,1'b0, 1'b0,4'b0000,2'd0,2'd0,2'd0,2'd0,3'd0,1'b1));
    // Full queue with push and pop in the same cycle: the pop happens and the push is refused.
    vecs.push_back(mkVec(1'b1,4'b0111,2'd1,2'd0,2'd0,1'b0,1'b0, 1'b1,4'b0111,2'd1,2'd0,2'd0,2'd2,3'd1,1'b1));
    vecs.push_back(mkVec(1'b1,4'b1011,2'd2,2'd1,2'd0,1'b0,1'b0, 1'b1,4'b0111,2'd1,2'd0,2'd0,2'd2,3'd2,1'b1));
    vecs.push_back(mkVec(1'b1,4'b0011,2'd0,2'd0,2'd0,1'b0,1'b0, 1'b1,4'b0111,2'd1,2'd0,2'd0,2'd2,3'd3,1'b1));
    vecs.push_back(mkVec(1'b1,4'b0000,2'd3,2'd3,2'd3,1'b0,1'b0, 1'b1,4'b0111,2'd1,2'd0,2'd0,2'd2,3'd4,1'b0));
    vecs.push_back(mkVec(1'b1,4'b1110,2'd2,2'd2,2'd2,1'b1,1'b0, 1'b1,4'b1011,2'd2,2'd1,2'd0,2'd1,3'd3,1'b1));
    vecs.push_back(mkVec(1'b0,4'b0000,2'd0,2'd0,2'd0,1'b1,1'b0, 1'b1,4'b0011,2'd0,2'd0,2'd0,2'd3,3'd2,1'b1));
    vecs.push_back(mkVec(1'b0,4'b0000,2'd0,2'd0,2'd0,1'b1,1'b0, 1'b1,4'b0000,2'd3,2'd3,2'd3,2'd0,3'd1,1'b1));
    vecs.push_back(mkVec(1'b0,4'b0000,2'd0,2'd0,2'd0,1'b1,1'b0, 1'b0,4'b0000,2'd0,2'd0,2'd0,2'd0,3'd0,1'b1));

    // State while reset is held.
    #12;
    checkOutput("reset", 1'b0, 4'd0, 2'd0, 2'd0, 2'd0, 2'd0, 3'd0, 1'b1);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d", i), vecs[i].expValid, vecs[i].expOpcode,
                  vecs[i].expA, vecs[i].expB, vecs[i].expC, vecs[i].expSel,
                  vecs[i].expCount, vecs[i].expReady);
    end

    // Asynchronous reset that arrives in mid-cycle while two entries are queued.
    applyStimulus(mkVec(1'b1,4'b1101,2'd1,2'd2,2'd3,1'b0,1'b0, 1'b0,4'd0,2'd0,2'd0,2'd0,2'd0,3'd0,1'b0));
    applyStimulus(mkVec(1'b1,4'b0110,2'd2,2'd1,2'd0,1'b0,1'b0, 1'b0,4'd0,2'd0,2'd0,2'd0,2'd0,3'd0,1'b0));
    checkOutput("preReset", 1'b1, 4'b1101, 2'd1, 2'd2, 2'd3, 2'd1, 3'd2, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("asyncReset", 1'b0, 4'd0, 2'd0, 2'd0, 2'd0, 2'd0, 3'd0, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("afterReset", 1'b0, 4'd0, 2'd0, 2'd0, 2'd0, 2'd0, 3'd0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
